// File: rtl/alu_io_pkg.sv
// Shared ALU I/O definitions: stage encodings, default widths and ALU opcodes
// used by the operand loader, the ALU and the LED display mux.
package alu_io_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'd0,
        ST_LOAD_B  = 2'd1,
        ST_LOAD_OP = 2'd2,
        ST_DONE    = 2'd3
    } stage_e;

    localparam logic [OP_W_DEF-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W_DEF-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W_DEF-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W_DEF-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W_DEF-1:0] ALU_XOR = 3'd4;
    localparam logic [OP_W_DEF-1:0] ALU_SLL = 3'd5;
    localparam logic [OP_W_DEF-1:0] ALU_SRL = 3'd6;
    localparam logic [OP_W_DEF-1:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioner: optional 2-flop synchronizer and debouncer
// (LOADER_DEBOUNCE_EN), followed by a rising-edge pulse on the clean level.
module btn_conditioner
`ifdef LOADER_DEBOUNCE_EN
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic clean_level;
    logic level_q;

`ifdef LOADER_DEBOUNCE_EN
    logic [1:0]  sync_reg;
    logic        stable_reg;
    logic [19:0] count_reg;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= 2'b00;
            stable_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], level};
            if (sync_reg[1] == stable_reg) begin
                count_reg <= '0;
            end else if (count_reg == DEBOUNCE_CYCLES - 20'd1) begin
                stable_reg <= sync_reg[1];
                count_reg  <= '0;
            end else begin
                count_reg <= count_reg + 20'd1;
            end
        end
    end

    assign clean_level = stable_reg;
`else
    assign clean_level = level;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= clean_level;
        end
    end

    assign pulse = clean_level & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles ALU operands A, B (LSB byte first) and the opcode from switch bytes,
// one byte per load press. Optional button debouncing via LOADER_DEBOUNCE_EN.
module alu_operand_loader
    import alu_io_pkg::*;
#(
    parameter int          DATA_W          = DATA_W_DEF,
    parameter int          OP_W            = OP_W_DEF,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        sw_data,
    input  logic              btn_load,
    input  logic              btn_clr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   ALU_OP,
    output logic              operands_valid,
    output logic              load_ack,
    output logic [1:0]        stage,
    output logic [1:0]        byte_idx
);

    localparam int         N_BYTES  = DATA_W / 8;
    localparam logic [1:0] LAST_IDX = 2'(N_BYTES - 1);

    if ((DATA_W % 8 != 0) || (DEBOUNCE_CYCLES == 20'd0)) begin : g_bad_params
        $error("alu_operand_loader: DATA_W must be a multiple of 8 and DEBOUNCE_CYCLES nonzero");
    end

    logic load_evt;
    logic clr_evt;

    btn_conditioner
`ifdef LOADER_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_load_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_load),
        .pulse (load_evt)
    );

    btn_conditioner
`ifdef LOADER_DEBOUNCE_EN
        #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_clr_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_clr),
        .pulse (clr_evt)
    );

    stage_e            stage_reg, stage_next;
    logic [1:0]        idx_reg, idx_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [OP_W-1:0]   op_reg, op_next;
    logic              valid_reg, valid_next;
    logic              ack_reg, ack_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= ST_LOAD_A;
            idx_reg   <= 2'd0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            valid_reg <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            stage_reg <= stage_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            valid_reg <= valid_next;
            ack_reg   <= ack_next;
        end
    end

    always_comb begin
        stage_next = stage_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        valid_next = valid_reg;
        ack_next   = 1'b0;

        // Clear wins over a simultaneous load; the load is dropped unacknowledged.
        if (clr_evt) begin
            stage_next = ST_LOAD_A;
            idx_next   = 2'd0;
            a_next     = '0;
            b_next     = '0;
            op_next    = '0;
            valid_next = 1'b0;
        end else if (load_evt) begin
            ack_next = 1'b1;
            case (stage_reg)
                ST_LOAD_A: begin
                    a_next[8*idx_reg +: 8] = sw_data;
                    if (idx_reg == LAST_IDX) begin
                        stage_next = ST_LOAD_B;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
                ST_LOAD_B: begin
                    b_next[8*idx_reg +: 8] = sw_data;
                    if (idx_reg == LAST_IDX) begin
                        stage_next = ST_LOAD_OP;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
                ST_LOAD_OP: begin
                    op_next    = sw_data[OP_W-1:0];
                    stage_next = ST_DONE;
                    valid_next = 1'b1;
                end
                default: begin
                    stage_next = ST_LOAD_A;
                    idx_next   = 2'd0;
                    a_next     = '0;
                    b_next     = '0;
                    op_next    = '0;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    assign A              = a_reg;
    assign B              = b_reg;
    assign ALU_OP         = op_reg;
    assign operands_valid = valid_reg;
    assign load_ack       = ack_reg;
    assign stage          = stage_reg;
    assign byte_idx       = idx_reg;

endmodule
